// File: rtl/accelerator_read_heads_parser.sv
// accelerator_read_heads_parser: splits DNC read-head interface words into key, strength, free-gate and mode streams
module accelerator_read_heads_parser #(
  parameter int DATA_SIZE = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int R = 4,
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    ready,
  input  logic [DATA_SIZE-1:0]    size_r_in,
  input  logic [DATA_SIZE-1:0]    size_w_in,
  input  logic [DATA_SIZE-1:0]    data_in,
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  output logic [DATA_SIZE-1:0]    k_out,
  output logic                    k_out_i_enable,
  output logic                    k_out_k_enable,
  output logic [DATA_SIZE-1:0]    beta_out,
  output logic                    beta_out_enable,
  output logic [DATA_SIZE-1:0]    f_out,
  output logic                    f_out_enable,
  output logic [DATA_SIZE-1:0]    pi_out,
  output logic                    pi_out_i_enable,
  output logic                    pi_out_p_enable,
  output logic [CONTROL_SIZE-1:0] head_index
);
  localparam int IB = R > 1 ? $clog2(R) : 1;
  localparam int KB = W > 1 ? $clog2(W) : 1;
  localparam logic [2:0] IDLE = 3'd0, KEY = 3'd1, BETA = 3'd2, FREE = 3'd3, MODE = 3'd4, DONE = 3'd5;
  logic [2:0] state;
  logic [IB-1:0] i, r_last;
  logic [KB-1:0] k, w_last;
  logic [1:0] p;
  logic [DATA_SIZE-1:0] r_clamp, w_clamp;
  logic acc;
  assign r_clamp = size_r_in > DATA_SIZE'(R) ? DATA_SIZE'(R) : size_r_in;
  assign w_clamp = size_w_in > DATA_SIZE'(W) ? DATA_SIZE'(W) : size_w_in;
  assign data_in_ready = state == KEY || state == BETA || state == FREE || state == MODE;
  assign ready = state == DONE;
  assign acc = data_in_valid && data_in_ready;
  // r and w are held as last-index values so the counters compare at their own width
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      i <= '0;
      k <= '0;
      p <= '0;
      r_last <= '0;
      w_last <= '0;
      k_out <= '0;
      beta_out <= '0;
      f_out <= '0;
      pi_out <= '0;
      head_index <= '0;
      {k_out_i_enable, k_out_k_enable, beta_out_enable, f_out_enable, pi_out_i_enable, pi_out_p_enable} <= '0;
    end else begin
      {k_out_i_enable, k_out_k_enable, beta_out_enable, f_out_enable, pi_out_i_enable, pi_out_p_enable} <= '0;
      if (acc) head_index <= CONTROL_SIZE'(i);
      case (state)
        IDLE: if (start) begin
          r_last <= IB'(r_clamp - 1'b1);
          w_last <= KB'(w_clamp - 1'b1);
          i <= '0;
          k <= '0;
          p <= '0;
          state <= (r_clamp == '0 || w_clamp == '0) ? DONE : KEY;
        end
        KEY: if (acc) begin
          k_out <= data_in;
          k_out_k_enable <= 1'b1;
          k_out_i_enable <= k == '0;
          k <= k == w_last ? '0 : k + 1'b1;
          state <= k == w_last ? BETA : KEY;
        end
        BETA: if (acc) begin
          beta_out <= data_in;
          beta_out_enable <= 1'b1;
          state <= FREE;
        end
        FREE: if (acc) begin
          f_out <= data_in;
          f_out_enable <= 1'b1;
          p <= '0;
          state <= MODE;
        end
        MODE: if (acc) begin
          pi_out <= data_in;
          pi_out_p_enable <= 1'b1;
          pi_out_i_enable <= p == 2'd0;
          p <= p == 2'd2 ? 2'd0 : p + 1'b1;
          if (p == 2'd2) begin
            state <= i == r_last ? DONE : KEY;
            i <= i == r_last ? i : i + 1'b1;
            k <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_accelerator_read_heads_parser.sv
// tb_accelerator_read_heads_parser: directed vectors with a queue scoreboard and a negedge output monitor
module tb_accelerator_read_heads_parser;
  logic clk = 0, rst = 0, start = 0, data_in_valid = 0;
  logic [63:0] size_r_in = 0, size_w_in = 0, data_in = 0;
  logic ready, data_in_ready, k_out_i_enable, k_out_k_enable, beta_out_enable, f_out_enable;
  logic pi_out_i_enable, pi_out_p_enable;
  logic [63:0] k_out, beta_out, f_out, pi_out, head_index;
  logic [327:0] all_out;
  typedef struct {
    logic [6:0] flags;
    logic [63:0] data;
    logic [63:0] head;
    int cyc;
    logic chk;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;

  accelerator_read_heads_parser dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .size_r_in(size_r_in), .size_w_in(size_w_in), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .k_out(k_out), .k_out_i_enable(k_out_i_enable), .k_out_k_enable(k_out_k_enable),
    .beta_out(beta_out), .beta_out_enable(beta_out_enable),
    .f_out(f_out), .f_out_enable(f_out_enable),
    .pi_out(pi_out), .pi_out_i_enable(pi_out_i_enable), .pi_out_p_enable(pi_out_p_enable),
    .head_index(head_index)
  );

  assign all_out = {ready, data_in_ready, k_out_i_enable, k_out_k_enable, beta_out_enable, f_out_enable,
                    pi_out_i_enable, pi_out_p_enable, k_out, beta_out, f_out, pi_out, head_index};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [6:0] got;
    logic [63:0] gd;
    exp_t e;
    got = {k_out_k_enable, k_out_i_enable, beta_out_enable, f_out_enable, pi_out_p_enable, pi_out_i_enable, ready};
    gd = k_out_k_enable ? k_out : beta_out_enable ? beta_out : f_out_enable ? f_out : pi_out;
    if (rst && got != '0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output flags=%b data=%0d cyc=%0d", got, gd, cyc);
      end else begin
        e = q.pop_front();
        if (got !== e.flags || cyc != e.cyc || (e.chk && (gd !== e.data || head_index !== e.head))) begin
          errors++;
          $display("FAIL stream got flags=%b data=%0d head=%0d cyc=%0d, expected flags=%b data=%0d head=%0d cyc=%0d",
                   got, gd, head_index, cyc, e.flags, e.data, e.head, e.cyc);
        end
      end
    end
  end

  task automatic run(input int sr, input int sw, input bit gap, input int stop_after, input bit mid_start,
                     input logic [63:0] base);
    int r, w, n, t;
    exp_t list[$];
    exp_t e;
    r = sr > 4 ? 4 : sr;
    w = sw > 8 ? 8 : sw;
    for (int h = 0; h < r && w > 0; h++) begin
      for (int kk = 0; kk < w; kk++) list.push_back('{{2'b11 & {1'b1, kk == 0}, 5'b0}, 0, h, 0, 1'b1});
      list.push_back('{7'b0010000, 0, h, 0, 1'b1});
      list.push_back('{7'b0001000, 0, h, 0, 1'b1});
      for (int pp = 0; pp < 3; pp++)
        list.push_back('{{4'b0000, 1'b1, pp == 0, h == r - 1 && pp == 2}, 0, h, 0, 1'b1});
    end
    @(posedge clk); #1;
    size_r_in = 64'(sr);
    size_w_in = 64'(sw);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    if (r == 0 || w == 0) begin
      q.push_back('{7'b0000001, 0, 0, cyc, 1'b0});
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (data_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL degenerate_data_in_ready got %b expected 0", data_in_ready);
        end
      end
      return;
    end
    n = 0;
    foreach (list[j]) begin
      if (n == stop_after) break;
      data_in_valid = 1;
      data_in = base + 64'(n);
      if (mid_start && n == 1) begin
        start = 1;
        size_r_in = 1;
        size_w_in = 1;
      end
      @(negedge clk);
      t = 0;
      while (!data_in_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got data_in_ready=0 expected 1 word=%0d", n);
        data_in_valid = 0;
        return;
      end
      @(posedge clk); #1;
      e = list[j];
      e.data = base + 64'(n);
      e.cyc = cyc;
      q.push_back(e);
      start = 0;
      data_in_valid = 0;
      if (gap) begin @(posedge clk); #1; end
      n++;
    end
    data_in_valid = 0;
  endtask

  task automatic drain;
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #3;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h expected 0", all_out); end
    #19 rst = 1;
    run(2, 3, 0, -1, 0, 1);  drain;
    run(2, 3, 1, -1, 0, 1);  drain;
    run(0, 3, 0, -1, 0, 1);  drain;
    run(2, 0, 0, -1, 0, 1);  drain;
    run(9, 20, 0, -1, 0, 100); drain;
    run(2, 3, 0, 7, 0, 200);
    @(negedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL async_reset_outputs got %h expected 0", all_out); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL abort_pending got %0d expected 0", q.size()); q.delete(); end
    repeat (2) @(posedge clk);
    #2 rst = 1;
    drain;
    run(2, 3, 0, -1, 0, 300); drain;
    run(2, 3, 0, -1, 1, 400); drain;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
